riscv_fetch: RTL and testbench

Parametrised instruction-fetch front end for the next-generation RISC-V core. It replaces the single-cycle PC and `instr` path with a decoupled unit. The unit issues pipelined, variable-latency requests to instruction memory over a valid/ready port and buffers responses with their PCs in a flushable queue. It hands instructions to decode over a second valid/ready port, and restarts cleanly on branch/jump redirects, discarding in-flight stale responses.

---
 rtl/riscv_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/riscv_fetch.sv | 111 +++++++++++
 tb/tb_riscv_fetch.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V core front end: default widths, reset PC and the canonical NOP.
package riscv_pkg;

  localparam int unsigned DEF_XLEN     = 32;
  localparam int unsigned INSTR_W      = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Flushable synchronous FIFO holding fetched {pc, instr} entries; head is exposed combinationally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_c,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count < CNT_W'(DEPTH));

  // Pointers and occupancy; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_c = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/riscv_fetch.sv
// Decoupled instruction fetch: credit-limited pipelined imem requests, response queue with PCs,
// and redirect handling that discards stale in-flight responses.
module riscv_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = DEF_XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc,
  output logic               align_err
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = XLEN + INSTR_W;

  logic [XLEN-1:0]    fetch_pc, fetch_pc_n;
  logic [XLEN-1:0]    rsp_pc, rsp_pc_n;
  logic [CNT_W-1:0]   in_flight, in_flight_n;
  logic [CNT_W-1:0]   drop_cnt, drop_cnt_n;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head_c;
  logic [XLEN-1:0]    redirect_base;
  logic               credit_ok;
  logic               req_fire;
  logic               rsp_ok;
  logic               rsp_keep;

  // Credit covers both queued entries and outstanding requests so a push can never overflow.
  assign credit_ok      = ({1'b0, in_flight} + {1'b0, count}) < (CNT_W + 1)'(DEPTH);
  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_ok         = imem_rsp_valid && (in_flight != '0);
  assign rsp_keep       = rsp_ok && (drop_cnt == '0) && !redirect_valid;
  assign redirect_base  = {redirect_pc[XLEN-1:2], 2'b00};

  // Next-state for PCs and credit/drop counters; redirect overrides normal updates.
  always_comb begin
    fetch_pc_n  = fetch_pc;
    rsp_pc_n    = rsp_pc;
    in_flight_n = in_flight;
    drop_cnt_n  = drop_cnt;
    if (redirect_valid) begin
      fetch_pc_n  = redirect_base;
      rsp_pc_n    = redirect_base;
      in_flight_n = in_flight - CNT_W'(rsp_ok);
      drop_cnt_n  = in_flight_n;
    end else begin
      if (req_fire) fetch_pc_n = fetch_pc + XLEN'(4);
      in_flight_n = in_flight + CNT_W'(req_fire) - CNT_W'(rsp_ok);
      if (rsp_ok && (drop_cnt != '0)) drop_cnt_n = drop_cnt - CNT_W'(1);
      if (rsp_keep) rsp_pc_n = rsp_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      rsp_pc    <= RESET_PC;
      in_flight <= '0;
      drop_cnt  <= '0;
      align_err <= 1'b0;
    end else begin
      fetch_pc  <= fetch_pc_n;
      rsp_pc    <= rsp_pc_n;
      in_flight <= in_flight_n;
      drop_cnt  <= drop_cnt_n;
      align_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (instr_valid && instr_ready),
    .head_c    (head_c),
    .count     (count)
  );

  assign instr_valid = (count != '0);
  assign instr_pc    = head_c[ENTRY_W-1:INSTR_W];
  assign instr       = head_c[INSTR_W-1:0];

  // Memory may only answer requests that are actually outstanding.
  a_rsp_has_credit: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (in_flight == '0)));

  // Stale responses are always a subset of outstanding ones.
  a_drop_within_flight: assert property (@(posedge clk) disable iff (rst)
    drop_cnt <= in_flight);

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed and randomised-latency bench for riscv_fetch with an in-order memory model and PC scoreboard.
module tb_riscv_fetch;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            align_err;

  riscv_fetch #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .align_err      (align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ird;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic        e_ae;
  } vec_t;

  int          checks = 0;
  int          passes = 0;
  int          cyc;
  int          last_due;
  int          lat_min = 1;
  int          lat_max = 1;
  int          ready_mode = 1;  // 0 stall, 1 always ready, 2 random
  int          ndeliv = 0;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] exp_pc;
  logic        ae_exp;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input int redir, input int rpc, input int ird, input int rv,
                              input int addr, input int iv, input int pc, input int ae);
    vec_t v;
    v.redir  = 1'(redir);
    v.rpc    = 32'(rpc);
    v.ird    = 1'(ird);
    v.e_rv   = 1'(rv);
    v.e_addr = 32'(addr);
    v.e_iv   = 1'(iv);
    v.e_pc   = 32'(pc);
    v.e_ae   = 1'(ae);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  // Drive one cycle's inputs (memory model response included) just after the falling edge.
  task automatic drive(input logic redir, input logic [31:0] rpc, input logic ird);
    if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mem_addr_q[0]);
      void'(mem_due_q.pop_front());
      void'(mem_addr_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    imem_req_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    redirect_valid = redir;
    redirect_pc    = rpc;
    instr_ready    = ird;
    #1;
  endtask

  // Record handshakes, score deliveries, then advance to the next falling edge.
  task automatic step();
    int due;
    chk("align_err", 32'(align_err), 32'(ae_exp));
    if (!instr_valid) begin
      chk("empty_instr", instr, 32'h0);
      chk("empty_pc", instr_pc, 32'h0);
    end
    if (imem_req_valid && imem_req_ready) begin
      due = cyc + int'($urandom_range(lat_min, lat_max));
      if (due <= last_due) due = last_due + 1;
      mem_addr_q.push_back(imem_req_addr);
      mem_due_q.push_back(due);
      last_due = due;
    end
    if (instr_valid && instr_ready) begin
      chk("deliver_pc", instr_pc, exp_pc);
      chk("deliver_data", instr, mem_data(exp_pc));
      exp_pc = exp_pc + 32'd4;
      ndeliv++;
    end
    if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    ae_exp = redirect_valid && (redirect_pc[1:0] != 2'b00);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    mem_addr_q.delete();
    mem_due_q.delete();
    last_due = -1;
    #1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_align_err", 32'(align_err), 32'h0);
    rst    = 1'b0;
    cyc    = 0;
    exp_pc = 32'h0;
    ae_exp = 1'b0;
  endtask

  initial begin
    vec_t tbl[26];
    int   n0;

    // redir rpc ird | req_valid req_addr instr_valid instr_pc align_err
    tbl[0]  = mk(0, 'h000, 1, 1, 'h000, 0, 'h000, 0);
    tbl[1]  = mk(0, 'h000, 1, 1, 'h004, 0, 'h000, 0);
    tbl[2]  = mk(0, 'h000, 1, 1, 'h008, 1, 'h000, 0);
    tbl[3]  = mk(0, 'h000, 1, 1, 'h00C, 1, 'h004, 0);
    tbl[4]  = mk(0, 'h000, 1, 1, 'h010, 1, 'h008, 0);
    tbl[5]  = mk(1, 'h100, 1, 0, 'h014, 1, 'h00C, 0);
    tbl[6]  = mk(0, 'h000, 1, 1, 'h100, 0, 'h000, 0);
    tbl[7]  = mk(0, 'h000, 1, 1, 'h104, 0, 'h000, 0);
    tbl[8]  = mk(0, 'h000, 1, 1, 'h108, 1, 'h100, 0);
    tbl[9]  = mk(1, 'h202, 1, 0, 'h10C, 1, 'h104, 0);
    tbl[10] = mk(0, 'h000, 1, 1, 'h200, 0, 'h000, 1);
    tbl[11] = mk(1, 'h300, 1, 0, 'h204, 0, 'h000, 0);
    tbl[12] = mk(0, 'h000, 1, 1, 'h300, 0, 'h000, 0);
    tbl[13] = mk(0, 'h000, 1, 1, 'h304, 0, 'h000, 0);
    tbl[14] = mk(0, 'h000, 1, 1, 'h308, 1, 'h300, 0);
    tbl[15] = mk(0, 'h000, 1, 1, 'h30C, 1, 'h304, 0);
    tbl[16] = mk(0, 'h000, 0, 1, 'h310, 1, 'h308, 0);
    tbl[17] = mk(0, 'h000, 0, 1, 'h314, 1, 'h308, 0);
    tbl[18] = mk(0, 'h000, 0, 0, 'h318, 1, 'h308, 0);
    tbl[19] = mk(0, 'h000, 0, 0, 'h318, 1, 'h308, 0);
    tbl[20] = mk(0, 'h000, 1, 0, 'h318, 1, 'h308, 0);
    tbl[21] = mk(0, 'h000, 1, 1, 'h318, 1, 'h30C, 0);
    tbl[22] = mk(0, 'h000, 1, 1, 'h31C, 1, 'h310, 0);
    tbl[23] = mk(0, 'h000, 1, 1, 'h320, 1, 'h314, 0);
    tbl[24] = mk(0, 'h000, 1, 1, 'h324, 1, 'h318, 0);
    tbl[25] = mk(0, 'h000, 1, 1, 'h328, 1, 'h31C, 0);

    // 1-cycle memory: streaming, redirects (aligned, misaligned, back-to-back), backpressure.
    cyc = 0;
    do_reset();
    lat_min = 1; lat_max = 1; ready_mode = 1;
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].redir, tbl[i].rpc, tbl[i].ird);
      chk($sformatf("t%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rv));
      chk($sformatf("t%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].e_iv));
      chk($sformatf("t%0d_instr_pc", i), instr_pc, tbl[i].e_pc);
      chk($sformatf("t%0d_align_err", i), 32'(align_err), 32'(tbl[i].e_ae));
      step();
    end

    // Redirect to 0x100 with three requests outstanding on a 4-cycle memory.
    do_reset();
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 3; i++) begin drive(1'b0, '0, 1'b1); step(); end
    drive(1'b1, 32'h100, 1'b1); step();
    n0 = ndeliv;
    for (int i = 0; i < 25; i++) begin drive(1'b0, '0, 1'b1); step(); end
    chk("seqA_delivered", 32'(ndeliv - n0 >= 10), 32'h1);

    // Back-to-back redirects while stale responses are still being dropped.
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 2; i++) begin drive(1'b0, '0, 1'b1); step(); end
    drive(1'b1, 32'h500, 1'b1); step();
    drive(1'b1, 32'h600, 1'b1); step();
    n0 = ndeliv;
    for (int i = 0; i < 20; i++) begin drive(1'b0, '0, 1'b1); step(); end
    chk("seqB_delivered", 32'(ndeliv - n0 >= 8), 32'h1);

    // Random latency 1..5, random ready on both sides, occasional redirects.
    lat_min = 1; lat_max = 5; ready_mode = 2;
    n0 = ndeliv;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) drive(1'b1, $urandom & 32'h0000_FFFF, 1'($urandom_range(0, 1)));
      else drive(1'b0, '0, ($urandom_range(0, 3) != 0));
      step();
    end
    chk("random_progress", 32'(ndeliv - n0 > 200), 32'h1);

    // Credit must be fully returned: exactly DEPTH entries fill the queue, then drain.
    lat_min = 1; lat_max = 1; ready_mode = 1;
    drive(1'b1, 32'h400, 1'b0); step();
    for (int i = 0; i < 30; i++) begin drive(1'b0, '0, 1'b0); step(); end
    drive(1'b0, '0, 1'b0);
    chk("full_req_valid", 32'(imem_req_valid), 32'h0);
    chk("full_instr_pc", instr_pc, 32'h400);
    step();
    ready_mode = 0;
    n0 = ndeliv;
    for (int i = 0; i < 10; i++) begin drive(1'b0, '0, 1'b1); step(); end
    chk("credit_drain", 32'(ndeliv - n0), 32'(DEPTH));

    // Reset mid-operation with requests outstanding, then restart from RESET_PC.
    ready_mode = 1; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 3; i++) begin drive(1'b0, '0, 1'b1); step(); end
    do_reset();
    drive(1'b0, '0, 1'b1);
    chk("restart_req_valid", 32'(imem_req_valid), 32'h1);
    chk("restart_req_addr", imem_req_addr, 32'h0);
    step();
    for (int i = 0; i < 10; i++) begin drive(1'b0, '0, 1'b1); step(); end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
